// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// Multi-digit BCD countdown timer loaded at run time by the controlling FSM.
// A start pulse loads a BCD duration (each nibble clamped to 9) and begins
// counting down once per second. The count can be paused and resumed without
// losing the sub-second position, aborted silently, and it flags a warning
// window (with a blink phase) near the end of the count.
//
// Parameters:
//   DIGITS        number of BCD digits (1..4); value width is 4*DIGITS
//   TICKS_PER_SEC clk cycles per second (>= 2, even)
//   TICK_W        tick counter width; must hold TICKS_PER_SEC-1
//   WARN_BCD      warn while value <= WARN_BCD (BCD encoded)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   load_value  BCD duration, sampled only when start is high
//   start       1-cycle pulse: load and begin (restarts a running count)
//   enable      high = count, low = pause
//   abort       1-cycle pulse: stop without done (wins over start)
//   value       current BCD count for the HEX digits
//   active      high while running or paused
//   warn        active && value <= WARN_BCD
//   blink       warn && first half of the current second
//   sec_tick    1-cycle pulse on each completed second
//   done        1-cycle pulse on natural expiry (coincides with sec_tick)
//
// All outputs come from registers or from logic on registered state only;
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int unsigned          DIGITS        = 2,
  parameter int unsigned          TICKS_PER_SEC = 50_000_000,
  parameter int unsigned          TICK_W        = 26,
  parameter logic [4*DIGITS-1:0]  WARN_BCD      = 'h05
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  enable,
  input  logic                  abort,
  output logic [4*DIGITS-1:0]   value,
  output logic                  active,
  output logic                  warn,
  output logic                  blink,
  output logic                  sec_tick,
  output logic                  done
);

  localparam int unsigned VW = 4 * DIGITS;

  // Last tick of a second and the first tick of its second half.
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICKS_PER_SEC / 2);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Force any non-decimal nibble (A..F) to 9 so the display never shows
  // garbage and the decrement below always operates on valid BCD.
  function automatic logic [VW-1:0] clamp_bcd(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // BCD decrement by one: a zero digit wraps to 9 and keeps borrowing from
  // the next digit up; the first non-zero digit absorbs the borrow.
  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              state_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [VW-1:0]       value_q;
  logic                sec_tick_q;
  logic                done_q;

  logic [VW-1:0]       load_clamped;
  logic [VW-1:0]       value_dec;
  logic                tick_last;

  assign load_clamped = clamp_bcd(load_value);
  assign value_dec    = bcd_dec(value_q);
  assign tick_last    = (tick_cnt_q == TICK_LAST);

  // Priority: abort > start > counting. In RUN or PAUSED, enable alone
  // decides whether this cycle counts; a PAUSED timer that sees enable
  // high counts on that same edge, so a pause of N cycles delays the
  // whole countdown by exactly N cycles.
  // NOTE: every register here is assigned with <= so all state updates
  // land together at the edge; blocking = in a clocked block would let
  // later statements see half-updated state and mis-simulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      value_q    <= '0;
      sec_tick_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Pulses default low and are only raised on the terminal tick.
      sec_tick_q <= 1'b0;
      done_q     <= 1'b0;

      if (abort) begin
        state_q    <= ST_IDLE;
        value_q    <= '0;
        tick_cnt_q <= '0;
      end else if (start) begin
        state_q    <= ST_RUN;
        value_q    <= load_clamped;
        tick_cnt_q <= '0;
      end else if (state_q != ST_IDLE) begin
        if (!enable) begin
          // Hold tick_cnt and value; only the state changes.
          state_q <= ST_PAUSED;
        end else begin
          state_q <= ST_RUN;
          if (!tick_last) begin
            tick_cnt_q <= tick_cnt_q + TICK_ONE;
          end else begin
            tick_cnt_q <= '0;
            sec_tick_q <= 1'b1;
            if (value_q != '0) begin
              value_q <= value_dec;
            end else begin
              // Zero has been shown for a full second: expire.
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (registered state only)
  // -------------------------------------------------------------------------
  assign value    = value_q;
  assign sec_tick = sec_tick_q;
  assign done     = done_q;
  assign active   = (state_q != ST_IDLE);

  // Unsigned compare of the packed BCD is order-preserving for valid BCD,
  // and value_q only ever holds valid BCD thanks to the load clamp.
  assign warn     = active && (value_q <= WARN_BCD);

  // tick_cnt_q holds while paused, so blink freezes with it.
  assign blink    = warn && (tick_cnt_q < TICK_HALF);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer
//
// Directed bench for bcd_countdown_timer with DIGITS=2, TICKS_PER_SEC=4.
// Expected per-cycle outputs for a countdown are computed from decimal
// arithmetic and pushed to a scoreboard queue when the start is driven;
// they are popped and compared as the DUT produces each cycle.
// ---------------------------------------------------------------------------
module tb_bcd_countdown_timer;

  localparam int          DIGITS = 2;
  localparam int          TPS    = 4;
  localparam int          TW     = 3;
  localparam int          WARN_D = 5;
  localparam logic [7:0]  WARN   = 8'h05;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] load_value;
  logic       start;
  logic       enable;
  logic       abort;
  logic [7:0] value;
  logic       active;
  logic       warn;
  logic       blink;
  logic       sec_tick;
  logic       done;

  bcd_countdown_timer #(
    .DIGITS        (DIGITS),
    .TICKS_PER_SEC (TPS),
    .TICK_W        (TW),
    .WARN_BCD      (WARN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_value (load_value),
    .start      (start),
    .enable     (enable),
    .abort      (abort),
    .value      (value),
    .active     (active),
    .warn       (warn),
    .blink      (blink),
    .sec_tick   (sec_tick),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] value;
    logic       active;
    logic       sec_tick;
    logic       done;
    logic       warn;
    logic       blink;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [7:0] to_bcd(input int d);
    return 8'(((d / 10) * 16) + (d % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for a countdown of decimal n, sampled once per cycle
  // starting the cycle after the start edge (c=0). An optional pause drops
  // enable at sample pause_at for pause_len cycles.
  task automatic push_run(input int n, input int pause_at, input int pause_len);
    int   total;
    int   ce;
    int   d;
    bit   held;
    exp_t e;
    total = (n + 1) * TPS + pause_len;
    for (int c = 0; c <= total; c++) begin
      held = 1'b0;
      if (pause_len > 0 && c > pause_at && c <= pause_at + pause_len) begin
        ce   = pause_at;
        held = 1'b1;
      end else if (pause_len > 0 && c > pause_at + pause_len) begin
        ce = c - pause_len;
      end else begin
        ce = c;
      end
      if (c == total) begin
        e = '{value: 8'h00, active: 1'b0, sec_tick: 1'b1, done: 1'b1,
              warn: 1'b0, blink: 1'b0};
      end else begin
        d          = n - ce / TPS;
        e.value    = to_bcd(d);
        e.active   = 1'b1;
        e.sec_tick = !held && ce > 0 && (ce % TPS) == 0;
        e.done     = 1'b0;
        e.warn     = (d <= WARN_D);
        e.blink    = e.warn && ((ce % TPS) < TPS / 2);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic compare_front(input string name, input int c);
    exp_t e;
    if (sb_q.size() == 0) begin
      check($sformatf("%s c%0d sb_empty", name, c), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("%s c%0d value", name, c), 32'(value), 32'(e.value));
      check($sformatf("%s c%0d active", name, c), 32'(active), 32'(e.active));
      check($sformatf("%s c%0d sec_tick", name, c), 32'(sec_tick), 32'(e.sec_tick));
      check($sformatf("%s c%0d done", name, c), 32'(done), 32'(e.done));
      check($sformatf("%s c%0d warn", name, c), 32'(warn), 32'(e.warn));
      check($sformatf("%s c%0d blink", name, c), 32'(blink), 32'(e.blink));
    end
  endtask

  // Called #1 after a clock edge; start takes effect on the next edge.
  task automatic drive_start(input logic [7:0] lv);
    start      = 1'b1;
    load_value = lv;
    step();
    start      = 1'b0;
  endtask

  task automatic run_full(input string name, input logic [7:0] lv, input int n,
                          input int pause_at, input int pause_len);
    int total;
    total = (n + 1) * TPS + pause_len;
    push_run(n, pause_at, pause_len);
    drive_start(lv);
    for (int c = 0; c <= total; c++) begin
      compare_front(name, c);
      if (pause_len > 0 && c == pause_at) enable = 1'b0;
      if (pause_len > 0 && c == pause_at + pause_len) enable = 1'b1;
      if (c < total) step();
    end
    check({name, " sb_drained"}, 32'(sb_q.size()), 32'd0);
    step();
    check({name, " done_cleared"}, 32'(done), 32'd0);
    check({name, " idle_after"}, 32'(active), 32'd0);
  endtask

  task automatic expect_quiet_idle(input string name, input int cycles);
    int done_seen;
    int active_seen;
    done_seen   = 0;
    active_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done)   done_seen++;
      if (active) active_seen++;
    end
    check({name, " no_done"}, 32'(done_seen), 32'd0);
    check({name, " stays_idle"}, 32'(active_seen), 32'd0);
    check({name, " value_zero"}, 32'(value), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    load_value = 8'h00;
    start      = 1'b0;
    enable     = 1'b1;
    abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state.
    check("rst value", 32'(value), 32'd0);
    check("rst active", 32'(active), 32'd0);
    check("rst warn", 32'(warn), 32'd0);
    check("rst blink", 32'(blink), 32'd0);
    check("rst sec_tick", 32'(sec_tick), 32'd0);
    check("rst done", 32'(done), 32'd0);

    // enable alone in IDLE does nothing.
    expect_quiet_idle("idle_enable", 5);

    // Basic 03 countdown: done 16 cycles after the start edge.
    run_full("run03", 8'h03, 3, -1, 0);

    // 12 countdown: BCD borrow at 10->09, warn from 05, blink pattern.
    run_full("run12", 8'h12, 12, -1, 0);

    // Pause at tick 2 for 10 cycles.
    run_full("pause02", 8'h02, 2, 2, 10);

    // Abort mid-count.
    push_run(5, -1, 0);
    drive_start(8'h05);
    for (int c = 0; c < 6; c++) begin
      compare_front("abort_pre", c);
      if (c < 5) step();
    end
    sb_q.delete();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort value", 32'(value), 32'd0);
    check("abort active", 32'(active), 32'd0);
    check("abort done", 32'(done), 32'd0);
    expect_quiet_idle("abort_post", 30);

    // start and abort together: abort wins.
    drive_start(8'h05);
    step();
    check("pre_both active", 32'(active), 32'd1);
    start      = 1'b1;
    abort      = 1'b1;
    load_value = 8'h09;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("both value", 32'(value), 32'd0);
    check("both active", 32'(active), 32'd0);
    expect_quiet_idle("both_post", 6);

    // Clamp 0F -> 09, full run.
    run_full("clamp0f", 8'h0F, 9, -1, 0);

    // Clamp A7 -> 97, then restart mid-count with 05.
    drive_start(8'hA7);
    check("clampA7 value", 32'(value), 32'h97);
    check("clampA7 warn", 32'(warn), 32'd0);
    check("clampA7 active", 32'(active), 32'd1);
    repeat (6) step();
    check("clampA7 later", 32'(value), 32'h96);
    run_full("restart05", 8'h05, 5, -1, 0);

    // Load 00: done after exactly one second.
    run_full("run00", 8'h00, 0, -1, 0);

    // Asynchronous reset mid-count.
    drive_start(8'h05);
    repeat (5) step();
    check("prerst active", 32'(active), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst value", 32'(value), 32'd0);
    check("arst active", 32'(active), 32'd0);
    check("arst warn", 32'(warn), 32'd0);
    check("arst blink", 32'(blink), 32'd0);
    check("arst sec_tick", 32'(sec_tick), 32'd0);
    check("arst done", 32'(done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    expect_quiet_idle("arst_post", 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
